tile_bram_arb: RTL and testbench
================================

Name: tile_bram_arb

Overview:
- Shares one `tile_bram` (one write port, one read port, 1-cycle registered read) between NREQ requesters, e.g. DMA fill, compute read, writeback drain.
- Two independent round-robin arbiters run in parallel: one for writes, one for reads. Each cycle, at most one write and one read are granted.
- Read data returns one cycle after grant, tagged to the granted requester.
- Sits between the tile-memory clients and the `tile_bram` instance it owns.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, data width
- DEPTH, 1024, words in tile memory; AW = $clog2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*W  packed write data
- req_ready  out  NREQ  request accepted this cycle (valid & ready = transfer)
- resp_valid  out  NREQ  one-hot; read data for requester i is valid
- resp_rdata  out  W  shared read data bus
- busy  out  1  any request pending or any read in flight

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Request classes:
  - Write requester: valid & we.
  - Read requester: valid & !we.
- Each class has its own rr_arbiter with a priority pointer.
- Grant rule: the grant goes to the first requesting index at or after the pointer, wrapping modulo NREQ.
- Grants and `req_ready` are combinational from `req_valid`/`req_we` and the pointers.
- `req_ready[i]` = write_grant[i] | read_grant[i]. At most one bit per class is set.
- Pointer update on grant to i: pointer <= (i+1) mod NREQ. A pointer holds when its class has no grant.
- Write path: a granted write drives BRAM we=1, waddr, wdata in the same cycle. Memory is updated at that clock edge.
- Read path:
  - Granted read drives re=1 and raddr in the same cycle.
  - Next cycle, `resp_valid` = one-hot of the granted index, registered, and `resp_rdata` = BRAM rdata.
  - Latency is exactly 1 cycle. No backpressure on responses; requesters must always accept.
- `resp_rdata` holds its last value when `resp_valid` is 0 (BRAM output is not re-enabled).
- Fairness: a continuously asserting requester waits at most NREQ-1 grants of its class.
- Read and write from different requesters in the same cycle: both are granted.
- Same-address read and write in the same cycle: the read returns OLD data (BRAM read-before-write), unless the bypass feature is enabled.
- `req_valid` deasserted: no grant; pointers unchanged.
- `busy` = |req_valid | (|resp_valid).
- Reset:
  - Values: both pointers = 0, `resp_valid` = 0, `busy` = 0, `req_ready` forced 0 while `rst` is high.
  - A read granted the cycle before reset asserts produces no `resp_valid`; the in-flight response is dropped.
  - Memory contents are not cleared.
- Assertions (sim): `req_ready` per class is one-hot0; `resp_valid` is one-hot0.

Optional Feature:
- Macro: TILE_BRAM_ARB_BYPASS_EN.
- Defined:
  - If the granted read and granted write in the same cycle have equal addresses, a registered bypass flag and wdata are captured.
  - Next cycle, `resp_rdata` = captured wdata (new data).
  - Adds one W-bit register and a flag.
- Undefined: old-data semantics as above; no extra logic.

Decomposition:
- Package `tile_pkg`: `TILE_W`, `TILE_DEPTH`, `TILE_AW` constants; `typedef logic [TILE_AW-1:0] tile_addr_t`; `typedef logic [TILE_W-1:0] tile_data_t`.
- Sub-module `rr_arbiter #(N)`:
  - Ports: clk, rst, req[N], gnt[N], gnt_valid.
  - Contains the pointer register and masked/unmasked priority select.
  - Instantiated twice (write, read).
- `tile_bram` is instantiated inside `tile_bram_arb`.

Test Plan:
- Single write then read: req0 writes 0xDEADBEEF at addr 5; next cycle req1 reads addr 5 -> `req_ready[1]`=1 on that cycle; the cycle after, `resp_valid`=4'b0010 and `resp_rdata`=0xDEADBEEF.
- Round-robin: all 4 requesters hold read requests for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each `resp_valid` bit appears one cycle after its grant.
- Parallel classes: req0 writes addr 10 while req2 reads addr 20 (preloaded 0x1234) -> both ready in the same cycle; next cycle `resp_valid`=4'b0100, data=0x1234.
- Collision: addr 7 holds 0x1111; req1 writes 0x2222 to addr 7 while req3 reads addr 7 -> response 0x1111 without the macro, 0x2222 with TILE_BRAM_ARB_BYPASS_EN; a later read returns 0x2222 in both builds.
- Reset mid-operation: grant a read at cycle N, assert `rst` at cycle N+1 -> no `resp_valid` at N+1, `req_ready`=0 during reset, first grant after reset goes to the lowest requesting index.
- Starvation bound: req0 requests every cycle while req3 requests once -> req3 is granted within 3 read grants.

Source files
------------

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile memory sizing constants and types
package tile_pkg;
  localparam int TILE_W     = 32;
  localparam int TILE_DEPTH = 1024;
  localparam int TILE_AW    = $clog2(TILE_DEPTH);

  typedef logic [TILE_AW-1:0] tile_addr_t;
  typedef logic [TILE_W-1:0]  tile_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, grant to first requester at or after the pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic [N-1:0]  mask;
  logic [N-1:0]  masked_req;
  logic          masked_hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr_q));
    end
    masked_req = req & mask;
    masked_hit = |masked_req;

    // Descending scan so the lowest eligible index is the one left standing.
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked_hit ? masked_req[i] : req[i]) begin
        gnt_idx = PW'(i);
      end
    end

    gnt_valid = |req;
    gnt       = '0;
    ptr_d     = ptr_q;
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d        = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/tile_bram.sv
// rtl/tile_bram.sv - simple dual-port tile memory, registered read-before-write output
module tile_bram #(
  parameter int W     = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;

  // Output register only loads on a read, so it holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/tile_bram_arb.sv
// rtl/tile_bram_arb.sv - shares one tile_bram between NREQ clients with separate write/read round-robin
// Optional same-cycle write-to-read bypass: TILE_BRAM_ARB_BYPASS_EN
module tile_bram_arb
  import tile_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = TILE_W,
  parameter int DEPTH = TILE_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_rdata,
  output logic              busy
);
  logic [NREQ-1:0] wr_req, rd_req;
  logic [NREQ-1:0] wr_gnt, rd_gnt;
  logic            wr_gnt_valid, rd_gnt_valid;
  logic [AW-1:0]   waddr, raddr;
  logic [W-1:0]    wdata;
  logic [W-1:0]    bram_rdata;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;

  // Requests are masked during reset so nothing is granted or written.
  always_comb begin
    wr_req = req_valid & req_we & {NREQ{~rst}};
    rd_req = req_valid & ~req_we & {NREQ{~rst}};
  end

  rr_arbiter #(.N(NREQ)) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (wr_req),
    .gnt       (wr_gnt),
    .gnt_valid (wr_gnt_valid)
  );

  rr_arbiter #(.N(NREQ)) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (rd_req),
    .gnt       (rd_gnt),
    .gnt_valid (rd_gnt_valid)
  );

  always_comb begin
    waddr = '0;
    wdata = '0;
    raddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wr_gnt[i]) begin
        waddr = req_addr[i*AW +: AW];
        wdata = req_wdata[i*W +: W];
      end
      if (rd_gnt[i]) begin
        raddr = req_addr[i*AW +: AW];
      end
    end
  end

  tile_bram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_bram (
    .clk   (clk),
    .we    (wr_gnt_valid),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_gnt_valid),
    .raddr (raddr),
    .rdata (bram_rdata)
  );

  always_comb begin
    req_ready    = wr_gnt | rd_gnt;
    resp_valid_d = rd_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
    end
  end

  // Gating with rst drops a response whose read was granted just before reset.
  assign resp_valid = resp_valid_q & {NREQ{~rst}};
  assign busy       = ~rst & ((|req_valid) | (|resp_valid));

`ifdef TILE_BRAM_ARB_BYPASS_EN
  logic         byp_sel_q, byp_sel_d;
  logic [W-1:0] byp_data_q, byp_data_d;

  // Selection only changes on a read so resp_rdata still holds between responses.
  always_comb begin
    byp_sel_d  = byp_sel_q;
    byp_data_d = byp_data_q;
    if (rd_gnt_valid) begin
      byp_sel_d = wr_gnt_valid && (waddr == raddr);
      if (wr_gnt_valid && (waddr == raddr)) begin
        byp_data_d = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    byp_sel_q  <= byp_sel_d;
    byp_data_q <= byp_data_d;
  end

  assign resp_rdata = byp_sel_q ? byp_data_q : bram_rdata;
`else
  assign resp_rdata = bram_rdata;
`endif

  a_wr_onehot0: assert property (@(posedge clk) $onehot0(wr_gnt));
  a_rd_onehot0: assert property (@(posedge clk) $onehot0(rd_gnt));
  a_resp_onehot0: assert property (@(posedge clk) $onehot0(resp_valid));
endmodule

// File: tb/tb_tile_bram_arb.sv
// tb/tb_tile_bram_arb.sv - self-checking bench for tile_bram_arb (vector table plus random vs model)
module tb_tile_bram_arb;
  localparam int NREQ  = 4;
  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

`ifdef TILE_BRAM_ARB_BYPASS_EN
  localparam logic [31:0] COLL_DATA = 32'h0000_2222;
`else
  localparam logic [31:0] COLL_DATA = 32'h0000_1111;
`endif

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [39:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rv;
    logic        exp_busy;
    logic        chk_data;
    logic [31:0] exp_rdata;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*W-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_rdata;
  logic              busy;

  always #5 clk = ~clk;

  tile_bram_arb #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  int          wptr_m = 0;
  int          rptr_m = 0;
  bit          pend_m = 0;
  int          pend_idx_m = 0;
  logic [31:0] last_m = '0;
  bit          last_known_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    if (i < 0) return 4'b0000;
    return 4'(1 << i);
  endfunction

  task automatic model_expect(output logic [3:0] er, output logic [3:0] erv, output logic eb);
    int wg, rg;
    wg  = pick(req_valid & req_we, wptr_m);
    rg  = pick(req_valid & ~req_we, rptr_m);
    er  = rst ? 4'b0000 : (onehot(wg) | onehot(rg));
    erv = (rst || !pend_m) ? 4'b0000 : onehot(pend_idx_m);
    eb  = !rst && ((|req_valid) || (|erv));
  endtask

  task automatic model_edge();
    int wg, rg;
    logic [9:0] ra, wa;
    logic [31:0] rd;
    bit rk;
    if (rst) begin
      wptr_m = 0;
      rptr_m = 0;
      pend_m = 0;
      return;
    end
    wg = pick(req_valid & req_we, wptr_m);
    rg = pick(req_valid & ~req_we, rptr_m);
    if (rg >= 0) begin
      ra = req_addr[rg*AW +: AW];
      rd = mem_m[ra];
      rk = known_m[ra];
`ifdef TILE_BRAM_ARB_BYPASS_EN
      if (wg >= 0 && req_addr[wg*AW +: AW] == ra) begin
        rd = req_wdata[wg*W +: W];
        rk = 1;
      end
`endif
      last_m       = rd;
      last_known_m = rk;
      rptr_m       = (rg + 1) % NREQ;
    end
    pend_m     = (rg >= 0);
    pend_idx_m = rg;
    if (wg >= 0) begin
      wa          = req_addr[wg*AW +: AW];
      mem_m[wa]   = req_wdata[wg*W +: W];
      known_m[wa] = 1;
      wptr_m      = (wg + 1) % NREQ;
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] we,
                              input logic [9:0] a0, input logic [9:0] a1,
                              input logic [9:0] a2, input logic [9:0] a3,
                              input logic [31:0] wd, input logic [3:0] er,
                              input logic [3:0] erv, input logic chk, input logic [31:0] ed);
    vec_t t;
    t.rst       = r;
    t.valid     = v;
    t.we        = we;
    t.addr      = {a3, a2, a1, a0};
    t.wdata     = wd;
    t.exp_ready = er;
    t.exp_rv    = erv;
    t.exp_busy  = !r && ((|v) || (|erv));
    t.chk_data  = chk;
    t.exp_rdata = ed;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [3:0] er, erv;
    logic eb;

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_we    = 4'b0101;
    req_addr  = '0;
    req_wdata = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("reset ready", 32'(req_ready), 32'h0);
      check("reset resp_valid", 32'(resp_valid), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      @(posedge clk); model_edge(); #1;
    end

    // write then read of addr 5
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 10'd5, 10'd0, 10'd0, 10'd0, 32'hDEADBEEF, 4'b0001, 4'b0000, 0, 32'h0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 10'd0, 10'd5, 10'd0, 10'd0, 32'h0, 4'b0010, 4'b0000, 0, 32'h0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0000, 4'b0010, 1, 32'hDEADBEEF));
    // preload 20 and 7
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 10'd20, 10'd0, 10'd0, 10'd0, 32'h1234, 4'b0001, 4'b0000, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 10'd7, 10'd0, 10'd0, 10'd0, 32'h1111, 4'b0001, 4'b0000, 0, 32'h0));
    // parallel write 10 / read 20
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 10'd10, 10'd0, 10'd20, 10'd0, 32'hAAAA, 4'b0101, 4'b0000, 0, 32'h0));
    // collision on addr 7
    tbl.push_back(mk(0, 4'b1010, 4'b0010, 10'd0, 10'd7, 10'd0, 10'd7, 32'h2222, 4'b1010, 4'b0100, 1, 32'h1234));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 10'd7, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0001, 4'b1000, 1, COLL_DATA));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0000, 4'b0001, 1, 32'h2222));
    // read granted, then reset drops it
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 10'd0, 10'd0, 10'd20, 10'd0, 32'h0, 4'b0100, 4'b0000, 1, 32'h2222));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b0000, 4'b0000, 0, 32'h0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0000, 4'b0000, 0, 32'h0));
    // round robin over all four readers
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b0001, 4'b0000, 0, 32'h0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b0010, 4'b0001, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b0100, 4'b0010, 1, 32'h2222));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b1000, 4'b0100, 1, 32'h1234));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b0001, 4'b1000, 1, 32'hAAAA));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b0010, 4'b0001, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b0100, 4'b0010, 1, 32'h2222));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 10'd5, 10'd7, 10'd20, 10'd10, 32'h0, 4'b1000, 4'b0100, 1, 32'h1234));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0000, 4'b1000, 1, 32'hAAAA));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0000, 4'b0000, 1, 32'hAAAA));
    // starvation bound: req0 always, req3 once
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 10'd5, 10'd0, 10'd0, 10'd20, 32'h0, 4'b0001, 4'b0000, 1, 32'hAAAA));
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 10'd5, 10'd0, 10'd0, 10'd20, 32'h0, 4'b1000, 4'b0001, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 10'd5, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0001, 4'b1000, 1, 32'h1234));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 32'h0, 4'b0000, 4'b0001, 1, 32'hDEADBEEF));

    foreach (tbl[i]) begin
      v         = tbl[i];
      rst       = v.rst;
      req_valid = v.valid;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = {4{v.wdata}};
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(v.exp_ready));
      check($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'(v.exp_rv));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(v.exp_busy));
      if (v.chk_data) check($sformatf("vec%0d rdata", i), resp_rdata, v.exp_rdata);
      @(posedge clk); model_edge(); #1;
    end

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      req_valid = 4'($urandom);
      req_we    = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i*AW +: AW] = 10'($urandom_range(0, 15));
        req_wdata[i*W +: W]  = $urandom;
      end
      @(negedge clk);
      model_expect(er, erv, eb);
      check($sformatf("rnd%0d ready", c), 32'(req_ready), 32'(er));
      check($sformatf("rnd%0d resp_valid", c), 32'(resp_valid), 32'(erv));
      check($sformatf("rnd%0d busy", c), 32'(busy), 32'(eb));
      if (last_known_m) check($sformatf("rnd%0d rdata", c), resp_rdata, last_m);
      @(posedge clk); model_edge(); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
